// File: rtl/lsu_mem_master.sv
// lsu_mem_master: initiator-side load/store unit in front of the memory controller port.
// Accepts one load or store at a time and builds the byte mask and lane-aligned store data.
// It holds the memory request for MEM_LATENCY cycles, then extends the load data and
// returns the result on a valid/ready response channel.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned half/word
// requests are answered with resp_err=1 and perform no memory access. When it is undefined,
// resp_err is always 0 and misaligned accesses use the truncated mask and shift rules.
// Legal MEM_LATENCY range is 1..15 (the latency counter is 4 bits wide).

module lsu_mem_master #(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_valid,
   output logic        mem_wen,
   output logic [31:0] mem_raddr,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam logic [3:0] CNT_LOAD  = 4'(MEM_LATENCY - 1);

   logic [1:0]  state_r;
   logic [3:0]  cnt_r;
   logic        req_ready_r;
   logic        mem_valid_r;
   logic        mem_wen_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  wmask_r;
   logic [1:0]  off_r;
   logic [1:0]  size_r;
   logic        unsigned_r;
   logic        is_store_r;
   logic        resp_valid_r;
   logic [31:0] resp_rdata_r;
   logic        resp_err_r;

   logic        trap_s;

   // Byte enables: shifted lane pattern, truncated to the 4 byte lanes of the word.
   function automatic logic [3:0] gen_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         2'd0:    m = 4'b0001 << off;
         2'd1:    m = 4'b0011 << off;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Store data moves from the low lanes up to the addressed byte lane.
   function automatic logic [31:0] align_wdata(input logic [31:0] data, input logic [1:0] off);
      return data << {off, 3'b000};
   endfunction

   // Load data moves down to the low lanes, then is sign- or zero-extended by size.
   function automatic logic [31:0] extract_load(input logic [31:0] raw, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
      logic [31:0] sh;
      logic [31:0] res;
      sh = raw >> {off, 3'b000};
      case (size)
         2'd0:    res = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'd1:    res = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   // Half-words must be 2-byte aligned; words (and size 3) must be 4-byte aligned.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         2'd0:    mis = 1'b0;
         2'd1:    mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

   assign trap_s = is_misaligned(req_size, req_addr[1:0]);
`else
   assign trap_s = 1'b0;
`endif

   // Request / access / response sequencing with all outputs held in registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 4'd0;
         req_ready_r  <= 1'b1;
         mem_valid_r  <= 1'b0;
         mem_wen_r    <= 1'b0;
         addr_r       <= 32'h0000_0000;
         wdata_r      <= 32'h0000_0000;
         wmask_r      <= 4'h0;
         off_r        <= 2'd0;
         size_r       <= 2'd0;
         unsigned_r   <= 1'b0;
         is_store_r   <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_r      <= {req_addr[31:2], 2'b00};
                  off_r       <= req_addr[1:0];
                  size_r      <= req_size;
                  unsigned_r  <= req_unsigned;
                  is_store_r  <= req_wen;
                  req_ready_r <= 1'b0;
                  if (trap_s) begin
                     // Misaligned: answer straight away, memory is never touched.
                     state_r      <= ST_RESP;
                     cnt_r        <= 4'd0;
                     wdata_r      <= 32'h0000_0000;
                     wmask_r      <= 4'h0;
                     resp_valid_r <= 1'b1;
                     resp_rdata_r <= 32'h0000_0000;
                     resp_err_r   <= 1'b1;
                  end else begin
                     state_r     <= ST_ACCESS;
                     cnt_r       <= CNT_LOAD;
                     wdata_r     <= align_wdata(req_wdata, req_addr[1:0]);
                     wmask_r     <= gen_mask(req_size, req_addr[1:0]);
                     mem_valid_r <= 1'b1;
                     mem_wen_r   <= req_wen;
                     resp_err_r  <= 1'b0;
                  end
               end
            end
            ST_ACCESS: begin
               // The write strobe lives only in the first access cycle so the
               // controller performs the store exactly once.
               mem_wen_r <= 1'b0;
               if (cnt_r == 4'd0) begin
                  state_r      <= ST_RESP;
                  mem_valid_r  <= 1'b0;
                  resp_valid_r <= 1'b1;
                  resp_rdata_r <= is_store_r ? 32'h0000_0000
                                             : extract_load(mem_rdata, size_r, off_r, unsigned_r);
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state_r      <= ST_IDLE;
                  resp_valid_r <= 1'b0;
                  resp_rdata_r <= 32'h0000_0000;
                  resp_err_r   <= 1'b0;
                  req_ready_r  <= 1'b1;
               end
            end
            default: begin
               // Unreachable encoding: fall back to a quiet idle state.
               state_r      <= ST_IDLE;
               cnt_r        <= 4'd0;
               req_ready_r  <= 1'b1;
               mem_valid_r  <= 1'b0;
               mem_wen_r    <= 1'b0;
               resp_valid_r <= 1'b0;
               resp_rdata_r <= 32'h0000_0000;
               resp_err_r   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_r;
   assign mem_valid  = mem_valid_r;
   assign mem_wen    = mem_wen_r;
   assign mem_raddr  = addr_r;
   assign mem_waddr  = addr_r;
   assign mem_wdata  = wdata_r;
   assign mem_wmask  = {4'b0000, wmask_r};
   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master. A small word memory stands in for the memory controller.
// The reference model computes byte lanes, masks and extensions straight from the
// load/store rules and keeps its own copy of the memory contents.

module tb_lsu_mem_master;

   localparam int LAT = 3;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_valid;
   logic        mem_wen;
   logic [31:0] mem_raddr;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic [31:0] mem_rdata;

   int tests = 0;
   int fails = 0;

   logic [31:0] bmem [16];
   logic [31:0] rmem [16];
   logic        pl_en;
   logic [3:0]  pl_idx;
   logic [31:0] pl_val;
   logic [31:0] wr_word;

   lsu_mem_master #(.MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_raddr(mem_raddr),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory read port: data visible combinationally during a read access.
   assign mem_rdata = (mem_valid && !mem_wen) ? bmem[mem_raddr[5:2]] : 32'h0000_0000;

   // Merge the masked store bytes into the addressed word.
   always_comb begin
      wr_word = bmem[mem_waddr[5:2]];
      for (int b = 0; b < 4; b++) begin
         if (mem_wmask[b]) wr_word[8*b +: 8] = mem_wdata[8*b +: 8];
      end
   end

   // Memory write port: preload from the bench, otherwise the DUT store strobe.
   always @(posedge clk) begin
      if (pl_en) bmem[pl_idx] <= pl_val;
      else if (mem_valid && mem_wen) bmem[mem_waddr[5:2]] <= wr_word;
   end

   function automatic logic [3:0] exp_mask(input logic [1:0] size, input logic [1:0] off);
      int n;
      logic [3:0] m;
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      m = 4'h0;
      for (int b = 0; b < 4; b++) begin
         if (n == 4 || (b >= int'(off) && b < int'(off) + n)) m[b] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] raw, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
      logic [31:0] v;
      v = raw >> (8 * off);
      if (size == 2'd0) begin
         v = v & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
         v = v & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic is_trap(input logic [1:0] size, input logic [1:0] off);
      return TRAP_EN && ((size == 2'd1 && off[0]) || (size >= 2'd2 && off != 2'd0));
   endfunction

   task automatic preload(input logic [3:0] i, input logic [31:0] v);
      pl_en = 1'b1; pl_idx = i; pl_val = v; rmem[i] = v;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // One full transaction: drive, watch the access phase, hold the response, hand it off.
   task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input int hold,
                         output logic [31:0] got);
      logic [1:0]  off;
      logic [3:0]  idx;
      logic [3:0]  m;
      logic [31:0] sw;
      logic [31:0] exp_rd;
      logic [31:0] exp_addr;
      logic        trap;
      int k, mv, wc, resp_at, bad, hbad;
      off = addr[1:0]; idx = addr[5:2]; trap = is_trap(size, addr[1:0]);
      m = exp_mask(size, off);
      sw = wdata << (8 * off);
      exp_addr = {addr[31:2], 2'b00};
      exp_rd = (wen || trap) ? 32'h0000_0000 : exp_load(rmem[idx], size, off, uns);
      k = 0;
      while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      tests++;
      if (req_ready !== 1'b1) begin fails++; $display("FAIL req_ready_wait: got %b want 1", req_ready); end
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
      req_size = size; req_unsigned = uns; resp_ready = 1'b0;
      @(negedge clk);
      if (wen && !trap) begin
         for (int b = 0; b < 4; b++) if (m[b]) rmem[idx][8*b +: 8] = sw[8*b +: 8];
      end
      mv = 0; wc = 0; resp_at = 0; bad = 0; k = 1;
      while (resp_at == 0 && k <= 40) begin
         if (mem_valid === 1'b1) begin
            mv++;
            if (mem_wen === 1'b1) wc++;
            if (mem_raddr !== exp_addr || mem_waddr !== exp_addr || mem_wmask !== {4'h0, m}
                || (wen && mem_wdata !== sw)) bad++;
         end
         if (resp_valid === 1'b1) resp_at = k;
         else begin
            // Junk on the request side and early resp_ready must both be ignored.
            req_valid = 1'($urandom_range(0, 1)); req_wen = 1'($urandom_range(0, 1));
            req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom_range(0, 3));
            resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk); k++;
         end
      end
      req_valid = 1'b0; resp_ready = 1'b0;
      tests++; if (mv != (trap ? 0 : LAT)) begin fails++; $display("FAIL mem_valid_cycles: got %0d want %0d", mv, trap ? 0 : LAT); end
      tests++; if (wc != ((wen && !trap) ? 1 : 0)) begin fails++; $display("FAIL mem_wen_cycles: got %0d want %0d", wc, (wen && !trap) ? 1 : 0); end
      tests++; if (resp_at != (trap ? 1 : LAT + 1)) begin fails++; $display("FAIL resp_latency: got %0d want %0d", resp_at, trap ? 1 : LAT + 1); end
      tests++; if (bad != 0) begin fails++; $display("FAIL access_fields addr=%h: %0d bad cycles, want 0", addr, bad); end
      tests++; if (resp_rdata !== exp_rd) begin fails++; $display("FAIL resp_rdata addr=%h size=%0d uns=%b: got %h want %h", addr, size, uns, resp_rdata, exp_rd); end
      tests++; if (resp_err !== trap) begin fails++; $display("FAIL resp_err: got %b want %b", resp_err, trap); end
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL req_ready_in_resp: got %b want 0", req_ready); end
      got = resp_rdata;
      hbad = 0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || req_ready !== 1'b0 || mem_valid !== 1'b0) hbad++;
      end
      tests++; if (hbad != 0) begin fails++; $display("FAIL resp_hold: %0d unstable cycles, want 0", hbad); end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_valid !== 1'b0) begin
         fails++; $display("FAIL after_handshake: resp_valid=%b req_ready=%b mem_valid=%b want 0 1 0", resp_valid, req_ready, mem_valid);
      end
      tests++; if (bmem[idx] !== rmem[idx]) begin fails++; $display("FAIL mem_contents idx=%0d: got %h want %h", idx, bmem[idx], rmem[idx]); end
   endtask

   task automatic test_reset();
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'h1234_5678;
      req_size = 2'd2; req_unsigned = 1'b0; rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (req_ready !== 1'b1 || mem_valid !== 1'b0 || resp_valid !== 1'b0 || mem_wen !== 1'b0) begin
         fails++; $display("FAIL reset_ctrl: rr=%b mv=%b rv=%b mw=%b want 1 0 0 0", req_ready, mem_valid, resp_valid, mem_wen);
      end
      tests++;
      if (resp_rdata !== 32'h0 || resp_err !== 1'b0 || mem_wmask !== 8'h00 || mem_wdata !== 32'h0 || mem_waddr !== 32'h0) begin
         fails++; $display("FAIL reset_data: rdata=%h err=%b wmask=%h wdata=%h waddr=%h want all 0", resp_rdata, resp_err, mem_wmask, mem_wdata, mem_waddr);
      end
      req_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         fails++; $display("FAIL reset_no_latch: mv=%b rv=%b rr=%b want 0 0 1", mem_valid, resp_valid, req_ready);
      end
   endtask

   task automatic test_store_word();
      logic [31:0] got;
      do_txn(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0, 1, got);
      tests++; if (bmem[1] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL store_word_mem: got %h want deadbeef", bmem[1]); end
      tests++; if (got !== 32'h0) begin fails++; $display("FAIL store_word_rdata: got %h want 0", got); end
   endtask

   task automatic test_store_byte();
      logic [31:0] got;
      do_txn(1'b1, 32'h8000_0003, 32'h0000_00A5, 2'd0, 1'b0, 0, got);
      tests++; if (bmem[0][31:24] !== 8'hA5) begin fails++; $display("FAIL store_byte_lane: got %h want a5", bmem[0][31:24]); end
   endtask

   task automatic test_load_ext();
      logic [31:0] got;
      preload(4'd2, 32'h0080_FF00);
      do_txn(1'b0, 32'h8000_0009, $urandom, 2'd0, 1'b0, 0, got);
      tests++; if (got !== 32'hFFFF_FFFF) begin fails++; $display("FAIL load_byte_signed: got %h want ffffffff", got); end
      do_txn(1'b0, 32'h8000_0009, $urandom, 2'd0, 1'b1, 0, got);
      tests++; if (got !== 32'h0000_00FF) begin fails++; $display("FAIL load_byte_unsigned: got %h want 000000ff", got); end
      do_txn(1'b0, 32'h8000_000A, $urandom, 2'd1, 1'b0, 0, got);
      tests++; if (got !== 32'h0000_0080) begin fails++; $display("FAIL load_half_signed: got %h want 00000080", got); end
   endtask

   task automatic test_backpressure();
      logic [31:0] got;
      do_txn(1'b0, 32'h8000_0000 + 32'(4 * $urandom_range(0, 15)), $urandom, 2'd2, 1'b0, 4, got);
   endtask

   task automatic test_misaligned();
      logic [31:0] got;
      do_txn(1'b0, 32'h8000_0002, $urandom, 2'd2, 1'b0, 1, got);
      do_txn(1'b1, 32'h8000_0007, $urandom, 2'd1, 1'b0, 0, got);
   endtask

   task automatic test_mid_reset();
      logic [31:0] addr;
      logic [31:0] wdata;
      int k, bad;
      addr = 32'h8000_0000 + 32'(4 * $urandom_range(0, 15));
      wdata = $urandom;
      k = 0;
      while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      req_valid = 1'b1; req_wen = 1'b1; req_addr = addr; req_wdata = wdata;
      req_size = 2'd2; req_unsigned = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      tests++; if (mem_wen !== 1'b1) begin fails++; $display("FAIL mid_reset_first_wen: got %b want 1", mem_wen); end
      rmem[addr[5:2]] = wdata;
      rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if (mem_valid !== 1'b0 || mem_wen !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         fails++; $display("FAIL mid_reset_outputs: mv=%b mw=%b rv=%b rr=%b want 0 0 0 1", mem_valid, mem_wen, resp_valid, req_ready);
      end
      rst_n = 1'b1;
      bad = 0;
      repeat (LAT + 2) begin
         @(negedge clk);
         if (resp_valid !== 1'b0 || mem_valid !== 1'b0) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL mid_reset_no_resp: %0d active cycles, want 0", bad); end
      tests++; if (bmem[addr[5:2]] !== rmem[addr[5:2]]) begin fails++; $display("FAIL mid_reset_store: got %h want %h", bmem[addr[5:2]], rmem[addr[5:2]]); end
   endtask

   task automatic test_random();
      logic [31:0] got;
      for (int i = 0; i < 40; i++) begin
         do_txn(1'($urandom_range(0, 1)), 32'h8000_0000 + 32'($urandom_range(0, 63)), $urandom,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2), got);
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
      pl_en = 1'b0; pl_idx = 4'd0; pl_val = 32'h0;
      for (int i = 0; i < 16; i++) preload(4'(i), $urandom);
      test_reset();
      test_store_word();
      test_store_byte();
      test_load_ext();
      test_backpressure();
      test_misaligned();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
